// File: rtl/seg7_pkg.sv
// Shared glyph constants, error code and capture FSM encoding for the
// multiplexed 7-segment capture path.
package seg7_pkg;

    // Segment order gfedcba, active-high
    localparam logic [6:0] SEG7_0 = 7'h3F;
    localparam logic [6:0] SEG7_1 = 7'h06;
    localparam logic [6:0] SEG7_2 = 7'h5B;
    localparam logic [6:0] SEG7_3 = 7'h4F;
    localparam logic [6:0] SEG7_4 = 7'h66;
    localparam logic [6:0] SEG7_5 = 7'h6D;
    localparam logic [6:0] SEG7_6 = 7'h7D;
    localparam logic [6:0] SEG7_7 = 7'h07;
    localparam logic [6:0] SEG7_8 = 7'h7F;
    localparam logic [6:0] SEG7_9 = 7'h6F;

    localparam logic [3:0] BCD_ERR = 4'hF;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } seg7_state_e;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational glyph-to-BCD re-encoder; anything that is not a legal 0-9
// glyph reads back as 0xF with err set.
module seg7_to_bcd
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] bcd,
    output logic       err
);

    always_comb begin
        bcd = BCD_ERR;
        err = 1'b1;
        case (seg)
            SEG7_0: begin bcd = 4'd0; err = 1'b0; end
            SEG7_1: begin bcd = 4'd1; err = 1'b0; end
            SEG7_2: begin bcd = 4'd2; err = 1'b0; end
            SEG7_3: begin bcd = 4'd3; err = 1'b0; end
            SEG7_4: begin bcd = 4'd4; err = 1'b0; end
            SEG7_5: begin bcd = 4'd5; err = 1'b0; end
            SEG7_6: begin bcd = 4'd6; err = 1'b0; end
            SEG7_7: begin bcd = 4'd7; err = 1'b0; end
            SEG7_8: begin bcd = 4'd8; err = 1'b0; end
            SEG7_9: begin bcd = 4'd9; err = 1'b0; end
            default: begin bcd = BCD_ERR; err = 1'b1; end
        endcase
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// Watches a multiplexed 7-segment display, captures each stable glyph into its
// digit slot and hands complete BCD frames out over valid/ready.
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        seg_i,
    input  logic [NDIG-1:0]   dig_sel_i,
    output logic [4*NDIG-1:0] frame_o,
    output logic [NDIG-1:0]   err_o,
    output logic              frame_valid_o,
    input  logic              frame_ready_i,
    output logic [0:0]        state_o
);

    // Handshake: a frame transfers on every rising edge where frame_valid_o
    // and frame_ready_i are both high; frame_o/err_o are stable while valid.

    localparam int CW = $clog2(STABLE_CYC + 1);
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [0:0] ST_COLLECT = COLLECT;
    localparam logic [0:0] ST_HOLD    = HOLD;

    logic [6:0]        samp_seg;
    logic [NDIG-1:0]   samp_sel;
    logic [CW-1:0]     cnt;
    logic              captured;
    logic              fire;
    logic              match;
    logic              sel_legal;
    logic              fire_set;
    logic [IW-1:0]     idx;
    logic [3:0]        dec_bcd;
    logic              dec_err;

    logic [4*NDIG-1:0] work_bcd;
    logic [NDIG-1:0]   work_err;
    logic [NDIG-1:0]   seen;
    logic [NDIG-1:0]   seen_n;
    logic              seen_full;
    logic              load;
    logic [0:0]        state;

    assign match     = (seg_i == samp_seg) && (dig_sel_i == samp_sel);
    assign sel_legal = (samp_sel != '0) && ((samp_sel & (samp_sel - 1'b1)) == '0);
    // Arm the capture on the edge where the count reaches STABLE_CYC-1; the
    // slot is written one edge later from the still-held sample register.
    assign fire_set  = match && sel_legal && !captured && (cnt == CW'(STABLE_CYC - 2));

    always_comb begin
        idx = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (samp_sel[i]) idx = IW'(i);
        end
    end

    seg7_to_bcd u_dec (
        .seg (samp_seg),
        .bcd (dec_bcd),
        .err (dec_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_seg <= '0;
            samp_sel <= '0;
            cnt      <= '0;
            captured <= 1'b0;
            fire     <= 1'b0;
        end else begin
            samp_seg <= seg_i;
            samp_sel <= dig_sel_i;
            fire     <= fire_set;
            if (!match || !sel_legal) begin
                cnt <= '0;
            end else if (cnt != CW'(STABLE_CYC)) begin
                cnt <= cnt + 1'b1;
            end
            if (!match) begin
                captured <= 1'b0;
            end else if (fire_set) begin
                captured <= 1'b1;
            end
        end
    end

    assign seen_full = &seen;
    assign load      = seen_full && ((state == ST_COLLECT) || frame_ready_i);

    // A capture landing on the load edge survives the clear and opens the next frame
    always_comb begin
        seen_n = load ? '0 : seen;
        if (fire) seen_n[idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_bcd <= '0;
            work_err <= '0;
            seen     <= '0;
        end else begin
            seen <= seen_n;
            if (fire) begin
                work_bcd[idx*4 +: 4] <= dec_bcd;
                work_err[idx]        <= dec_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_COLLECT;
            frame_o       <= '0;
            err_o         <= '0;
            frame_valid_o <= 1'b0;
        end else begin
            case (state)
                ST_COLLECT: begin
                    if (seen_full) begin
                        frame_o       <= work_bcd;
                        err_o         <= work_err;
                        frame_valid_o <= 1'b1;
                        state         <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (frame_ready_i) begin
                        if (seen_full) begin
                            frame_o       <= work_bcd;
                            err_o         <= work_err;
                            frame_valid_o <= 1'b1;
                        end else begin
                            frame_valid_o <= 1'b0;
                            state         <= ST_COLLECT;
                        end
                    end
                end
                default: begin
                    state         <= ST_COLLECT;
                    frame_valid_o <= 1'b0;
                end
            endcase
        end
    end

    assign state_o = state;

endmodule

// File: doc/seg7_scan_reader.md
# seg7_scan_reader

Capture block for the multiplexed 7-segment display path: it watches the segment lines and one-hot digit select, and re-encodes each stable glyph back to a BCD digit. It is the inverse of the BCD-to-segment decoders in the display path. Digits are assembled into a frame and handed off over a valid/ready handshake, so display-side tests can check displayed values against expected BCD. Glyphs that do not match a legal 0–9 pattern are flagged per digit.

## Interface
- NDIG, 4, number of multiplexed digits; legal range 1–8.
- STABLE_CYC, 3, consecutive rising edges a {dig_sel, seg} value must be held before capture; legal range 2–15.

- clk  input  1  single clock, rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- seg_i  input  7  segment lines, active-high; bit0=a … bit6=g.
- dig_sel_i  input  NDIG  digit select, one-hot; bit0 = least-significant digit.
- frame_o  output  4*NDIG  BCD frame; nibble k = digit k.
- err_o  output  NDIG  bit k set = digit k glyph was illegal (its nibble reads 0xF).
- frame_valid_o  output  1  frame_o/err_o valid.
- frame_ready_i  input  1  consumer accepts the frame.

## Operation
- Input stage: seg_i and dig_sel_i are registered every cycle into the sample register.
- Stability counter:
  - Compares each new pin value with the sample register.
  - On a match it increments and saturates at STABLE_CYC.
  - On a mismatch it clears to 0.
  - Capture fires once when the count reaches STABLE_CYC-1 and the sample is still unchanged.
  - A captured flag blocks re-capture until the pin value changes.
- Legal select: exactly one bit of the sample dig_sel is high. Zero or multi-hot select never captures and holds the counter at 0.
- Decode (gfedcba hex): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Any other pattern decodes to 0xF with err=1.
- Capture behaviour:
  - Writes the nibble and err bit into working slot k and sets seen[k].
  - Re-capture of an already-seen slot overwrites it; the newest value wins.
- FSM:
  - COLLECT: when seen is all ones, copy the working slots to frame_o/err_o, clear seen, assert frame_valid_o, go to HOLD.
  - HOLD: frame_o/err_o/frame_valid_o are frozen. Captures continue into the working slots.
  - HOLD, on frame_valid_o & frame_ready_i:
    - If seen is all ones in that cycle: reload from the working slots, clear seen, keep valid=1, stay in HOLD.
    - Otherwise: drop valid and go to COLLECT.
- Simultaneous capture and frame load: the capture written in that edge lands in the working slot and its seen bit is set after the clear, so it counts toward the next frame.
- Reset (asynchronous, any time including mid-frame):
  - State = COLLECT; counter, captured flag, seen, working slots, sample register = 0.
  - frame_o = 0, err_o = 0, frame_valid_o = 0.
  - A partial frame is discarded.

## Timing
- A pin value constant across rising edges E1..E(STABLE_CYC) is written into its slot at edge E(STABLE_CYC+1).
- With the default STABLE_CYC=3: edges 1–3 constant, slot written at edge 4.
- frame_valid_o rises at the edge after the last slot write (edge 5 for the final digit with defaults).
- Handshake completes on any rising edge with valid & ready both high.
- Back-to-back frames are possible: valid stays high with no bubble when the next frame is already complete.
- frame_ready_i may be held high permanently. frame_valid_o never depends combinationally on frame_ready_i.
- All outputs are registered.

## Structure
- Shared package seg7_pkg holds:
  - the ten glyph constants (SEG7_0..SEG7_9);
  - the BCD error code 4'hF;
  - the FSM state enum {COLLECT, HOLD}.
- Sub-module seg7_to_bcd: combinational 7-bit glyph → {err, 4-bit BCD}, instantiated once on the sample register.
- Top level holds the sample/stability logic, one-hot check and index encode, working slots, FSM and output registers.

## Test plan
- Reset then scan digits 0..3 with glyphs 3F, 06, 5B, 4F, each held 3 edges → frame_o = 16'h3210, err_o = 0, valid high at edge 5 after the last glyph; ready=1 → valid low next edge.
- Glyph 6F held only 2 edges, then 7F held 3 edges on the same digit → the slot reads 8, never 9.
- Glyph 0x49 on digit 2 → nibble 2 = 0xF, err_o = 4'b0100.
- dig_sel_i = 4'b0000 and 4'b0110 with stable 3F for 10 edges → no seen bit set, no frame.
- Frame 1 held (ready=0) while frame 2 (digits 9,8,7,6) fully captures; then ready=1 for one edge → frame_o = 16'h6789 with valid continuous; next ready → valid low.
- Assert rst_n low mid-scan after 2 digits → all outputs 0 immediately; after release, 4 fresh digits are required before valid.
